uart_param: RTL and testbench

Parametrised second-generation UART for the data logger: one transmitter and one receiver sharing a clock, with configurable bit period, data width and stop-bit count, mid-bit receive sampling with false-start rejection, and framing-error reporting. It sits between the logger's byte-stream producers/consumers and the board serial pins. It replaces the fixed 8N1 UART with a drop-in-compatible port set plus a `tx_ready` handshake and error flags.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 102 ++++++++++
 rtl/uart_param.sv | 110 +++++++++++
 tb/tb_uart_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared state encodings and constants for uart_param
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core : synchroniser, mid-bit sampling counter and RX FSM (UART_PARITY_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam int             IW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  rx_state_t              state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_prev;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   pbit;
  logic                   bit_end, mid, fall;

  assign rx_s    = sync[SYNC_STAGES-1];
  assign bit_end = (cnt == CNT_LAST);
  assign mid     = (cnt == CNT_MID);
  assign fall    = rx_prev & ~rx_s;

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:   if (fall) state_nx = RX_START;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START:  if (mid && rx_s) state_nx = RX_IDLE;
                 else if (bit_end) state_nx = RX_DATA;
      RX_DATA:   if (bit_end && idx == IDX_LAST) state_nx = PAR_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (bit_end) state_nx = RX_STOP;
      RX_STOP:   if (mid) state_nx = RX_IDLE;
      default:   state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      pbit       <= 1'b0;
      data_out   <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], rx};
      rx_prev    <= rx_s;
      state      <= state_nx;
      data_ready <= 1'b0;
      if (state_nx != state || state == RX_IDLE || bit_end) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);
      if (state_nx != state) idx <= '0;
      else if (bit_end)      idx <= idx + IW'(1);
      if (mid) begin
        case (state)
          RX_DATA:   shreg <= {rx_s, shreg[DATA_BITS-1:1]};
          RX_PARITY: pbit  <= rx_s;
          RX_STOP: begin
            data_out   <= shreg;
            frame_err  <= ~rx_s;
            parity_err <= PAR_EN & (^shreg ^ pbit ^ 1'(PARITY_ODD));
            data_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_param.sv
// ---------------------------------------------------------------------------
// uart_param : parametrised UART, TX FSM plus uart_rx_core (UART_PARITY_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 new_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam int             IW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]  IDX_DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]  IDX_SLAST = IW'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  tx_state_t            state, state_nx;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 bit_end, last_stop, accept;

  assign bit_end   = (cnt == CNT_LAST);
  assign last_stop = (state == TX_STOP) && bit_end && (idx == IDX_SLAST);
  // tx is registered one cycle behind state, so opening the handshake in the
  // final STOP cycle lets the next start bit follow the stop bit directly.
  assign tx_ready  = (state == TX_IDLE) || last_stop;
  assign accept    = new_data && tx_ready;

  always_comb begin
    state_nx = state;
    case (state)
      TX_IDLE:   if (accept) state_nx = TX_START;
      TX_START:  if (bit_end) state_nx = TX_DATA;
      TX_DATA:   if (bit_end && idx == IDX_DLAST) state_nx = PAR_EN ? TX_PARITY : TX_STOP;
      TX_PARITY: if (bit_end) state_nx = TX_STOP;
      TX_STOP:   if (last_stop) state_nx = accept ? TX_START : TX_IDLE;
      default:   state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == TX_IDLE || bit_end) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);
      if (state_nx != state) idx <= '0;
      else if (bit_end)      idx <= idx + IW'(1);
      if (accept) begin
        shreg <= data_in;
        par   <= ^data_in ^ 1'(PARITY_ODD);
      end else if (state == TX_DATA && bit_end) begin
        shreg <= shreg >> 1;
      end
      case (state)
        TX_START:  tx <= 1'b0;
        TX_DATA:   tx <= shreg[0];
        TX_PARITY: tx <= par;
        default:   tx <= 1'b1;
      endcase
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY_ODD   (PARITY_ODD)
  ) u_rx_core (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_param.sv
// ---------------------------------------------------------------------------
// tb_uart_param : directed self-checking bench for uart_param (UART_PARITY_EN aware)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_param;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SB  = 1;
`ifdef UART_PARITY_EN
  localparam int PB        = 1;
  localparam int N_FRAMES  = 8;
`else
  localparam int PB        = 0;
  localparam int N_FRAMES  = 6;
`endif
  localparam int NB = 1 + DB + PB + SB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_data = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;
  logic       rx;
  logic       tx_ready, tx, data_ready, frame_err, parity_err;
  logic [7:0] data_out;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_rdy = 0;
  int         n_long = 0;
  logic       prev_dr = 1'b0;
  logic [9:0] rx_q[$];

  assign rx = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_param #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .new_data   (new_data),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .rx         (rx),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always @(negedge clk) begin
    if (data_ready) begin
      n_rdy++;
      rx_q.push_back({parity_err, frame_err, data_out});
    end
    if (data_ready && prev_dr) n_long++;
    prev_dr = data_ready;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400 && !tx_ready; i++) @(negedge clk);
    check_eq("ready_wait", {31'd0, tx_ready}, 1);
  endtask

  // Samples every cycle of a frame; each bit must hold from its first to last cycle.
  task automatic check_bits(input logic [7:0] d, input int mode, input logic [7:0] nxt);
    logic [NB-1:0] exp;
    logic          first, last;
    bit            chained;
    chained = 1'b0;
    first   = 1'b0;
    exp     = '1;
    exp[0]  = 1'b0;
    for (int i = 0; i < DB; i++) exp[1+i] = d[i];
`ifdef UART_PARITY_EN
    exp[1+DB] = ^d;
`endif
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (new_data) new_data = 1'b0;
        else if (mode == 1 && !chained && k == NB - 1 && tx_ready) begin
          data_in  = nxt;
          new_data = 1'b1;
          chained  = 1'b1;
        end else if (mode == 2 && k * CPB + j == 50) begin
          data_in  = 8'hFF;
          new_data = 1'b1;
        end
        if (j == 0) first = tx;
        if (j == CPB - 1) begin
          last = tx;
          check_eq($sformatf("txbit%0d", k), {30'd0, first, last}, {30'd0, exp[k], exp[k]});
        end
      end
    end
    if (mode == 1) check_eq("b2b_ready", {31'd0, chained}, 1);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input logic [7:0] nxt);
    @(negedge clk);
    wait_ready();
    data_in  = d;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    check_eq("tx_latency", {31'd0, tx}, 1);
    check_bits(d, mode, nxt);
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic fe, input logic pe);
    logic [9:0] v;
    for (int i = 0; i < 200 && rx_q.size() == 0; i++) @(negedge clk);
    check_eq("rx_avail", {31'd0, rx_q.size() > 0}, 1);
    if (rx_q.size() > 0) begin
      v = rx_q.pop_front();
      check_eq("rx_data", {24'd0, v[7:0]}, {24'd0, d});
      check_eq("rx_frame_err", {31'd0, v[8]}, {31'd0, fe});
      check_eq("rx_parity_err", {31'd0, v[9]}, {31'd0, pe});
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic pbit);
    logic [NB-1:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DB; i++) b[1+i] = d[i];
`ifdef UART_PARITY_EN
    b[1+DB] = pbit;
`endif
    b[NB-1] = stop_v;
    @(negedge clk);
    for (int k = 0; k < NB; k++) begin
      rx_drv = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 1);
    check_eq("rst_tx_ready", {31'd0, tx_ready}, 1);
    check_eq("rst_data_ready", {31'd0, data_ready}, 0);
    check_eq("rst_data_out", {24'd0, data_out}, 0);
    check_eq("rst_frame_err", {31'd0, frame_err}, 0);
    check_eq("rst_parity_err", {31'd0, parity_err}, 0);
    rst = 1'b0;

    send(8'h06, 0, 8'h00);
    expect_rx(8'h06, 1'b0, 1'b0);

    send(8'd110, 1, 8'd99);
    check_bits(8'd99, 0, 8'h00);
    expect_rx(8'd110, 1'b0, 1'b0);
    expect_rx(8'd99, 1'b0, 1'b0);

    send(8'h5A, 2, 8'h00);
    expect_rx(8'h5A, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_eq("busy_tx_ready", {31'd0, tx_ready}, 1);
    repeat (200) @(negedge clk);
    check_eq("busy_no_extra", rx_q.size(), 0);

    base = n_rdy;
    @(negedge clk);
    wait_ready();
    data_in  = 8'h00;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("rstmid_tx_low", {31'd0, tx}, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_tx", {31'd0, tx}, 1);
    check_eq("rstmid_ready", {31'd0, tx_ready}, 1);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    check_eq("rstmid_no_rdy", n_rdy - base, 0);

    loop_en = 1'b0;
    rx_drv  = 1'b1;
    base    = n_rdy;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("glitch_no_rdy", n_rdy - base, 0);

    drive_frame(8'hA5, 1'b0, 1'b0);
    expect_rx(8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("fe_held", {31'd0, frame_err}, 1);
    check_eq("dout_held", {24'd0, data_out}, 32'hA5);
    drive_frame(8'h3C, 1'b1, 1'b0);
    expect_rx(8'h3C, 1'b0, 1'b0);

`ifdef UART_PARITY_EN
    repeat (10) @(negedge clk);
    loop_en = 1'b1;
    send(8'h07, 0, 8'h00);
    expect_rx(8'h07, 1'b0, 1'b0);
    loop_en = 1'b0;
    drive_frame(8'h07, 1'b1, 1'b0);
    expect_rx(8'h07, 1'b0, 1'b1);
`endif

    repeat (20) @(negedge clk);
    check_eq("dr_one_cycle", n_long, 0);
    check_eq("rdy_total", n_rdy, N_FRAMES);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
